// File: rtl/periph_uart_pkg.sv
`default_nettype none
// ============================================================================
// Module      : periph_uart_pkg
// Description : Shared definitions for the memory-mapped UART transmitter:
//               register word offsets, STATUS bit positions and the TX FSM
//               state encoding.
// Ports       : none (package)
// Revision    : 1.0 - initial release
// ============================================================================
package periph_uart_pkg;

  // Register word offsets (byte address[3:2])
  localparam logic [1:0] c_addr_data   = 2'd0;
  localparam logic [1:0] c_addr_status = 2'd1;
  localparam logic [1:0] c_addr_baud   = 2'd2;
  localparam logic [1:0] c_addr_rsvd   = 2'd3;

  // STATUS register bit positions
  localparam int c_st_full      = 0;
  localparam int c_st_empty     = 1;
  localparam int c_st_busy      = 2;
  localparam int c_st_overflow  = 3;
  localparam int c_st_idle      = 4;
  localparam int c_st_level_lsb = 8;
  localparam int c_st_level_w   = 4;

  // Transmit FSM states
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } tx_state_e;

endpackage : periph_uart_pkg
`default_nettype wire

// File: rtl/periph_uart_tx_fifo.sv
`default_nettype none
// ============================================================================
// Module      : uart_tx_fifo
// Description : Synchronous byte FIFO feeding the UART shifter. A push is
//               accepted only when the FIFO is not full at the start of the
//               cycle; a same-cycle pop never frees a slot for it and there
//               is no write-to-read bypass.
// Ports       : clk, reset      - clock, asynchronous active-high reset
//               i_push, i_wdata - write strobe and data
//               i_pop           - read strobe (ignored while empty)
//               o_rdata         - head-of-FIFO data
//               o_full, o_empty - occupancy flags
//               o_level         - entry count, 0..DEPTH
// Revision    : 1.0 - initial release
// ============================================================================
module uart_tx_fifo #(
  parameter  int DEPTH = 8,
  parameter  int WIDTH = 8,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_wdata,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_rdata,
  output logic             o_full,
  output logic             o_empty,
  output logic [AW:0]      o_level
);

  // Pointers carry an extra wrap bit so full and empty are distinguishable.
  logic [AW:0]      wptr_q, wptr_d;
  logic [AW:0]      rptr_q, rptr_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];

  logic w_push_ok;
  logic w_pop_ok;

  assign o_empty = (wptr_q == rptr_q);
  assign o_full  = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
  assign o_level = wptr_q - rptr_q;
  assign o_rdata = mem_q[rptr_q[AW-1:0]];

  assign w_push_ok = i_push && !o_full;
  assign w_pop_ok  = i_pop && !o_empty;

  always_comb begin
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    mem_d  = mem_q;
    if (w_push_ok) begin
      mem_d[wptr_q[AW-1:0]] = i_wdata;
      wptr_d                = wptr_q + (AW+1)'(1);
    end
    if (w_pop_ok) begin
      rptr_d = rptr_q + (AW+1)'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wptr_q <= '0;
      rptr_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      mem_q  <= mem_d;
    end
  end

endmodule : uart_tx_fifo
`default_nettype wire

// File: rtl/periph_uart_tx.sv
`default_nettype none
// ============================================================================
// Module      : periph_uart_tx
// Description : Memory-mapped 8N1 UART transmitter. Decoded bus commands
//               write DATA/STATUS/BAUD; reads return registered data one
//               cycle later with no wait states. Bytes are buffered in a
//               FIFO and shifted out LSB first on uart_tx.
// Ports       : clk, reset   - clock, asynchronous active-high reset
//               cmd_valid    - command valid and this peripheral selected
//               cmd_wr       - 1 = write, 0 = read
//               cmd_addr     - register word offset
//               cmd_wdata    - write data
//               rsp_rdata    - read data, valid the cycle after a read
//               uart_tx      - serial output, idle high
//               irq_tx_idle  - level: FIFO empty and shifter idle
// Revision    : 1.0 - initial release
// ============================================================================
module periph_uart_tx
  import periph_uart_pkg::*;
#(
  parameter int FIFO_DEPTH      = 8,
  parameter int DIV_BITS        = 16,
  parameter int CLK_DIV_DEFAULT = 434
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cmd_valid,
  input  logic        cmd_wr,
  input  logic [1:0]  cmd_addr,
  input  logic [31:0] cmd_wdata,
  output logic [31:0] rsp_rdata,
  output logic        uart_tx,
  output logic        irq_tx_idle
);

  localparam int c_aw = $clog2(FIFO_DEPTH);

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  tx_state_e           state_q, state_d;
  logic [DIV_BITS-1:0] timer_q, timer_d;
  logic [DIV_BITS-1:0] baud_q, baud_d;
  logic [2:0]          bit_cnt_q, bit_cnt_d;
  logic [7:0]          shift_q, shift_d;
  logic                uart_tx_q, uart_tx_d;
  logic                overflow_q, overflow_d;
  logic [31:0]         rdata_q, rdata_d;

  // --------------------------------------------------------------------------
  // Command decode
  // --------------------------------------------------------------------------
  logic w_wr;
  logic w_rd;
  logic w_wr_data;
  logic w_wr_status;
  logic w_wr_baud;

  assign w_wr        = cmd_valid && cmd_wr;
  assign w_rd        = cmd_valid && !cmd_wr;
  assign w_wr_data   = w_wr && (cmd_addr == c_addr_data);
  assign w_wr_status = w_wr && (cmd_addr == c_addr_status);
  assign w_wr_baud   = w_wr && (cmd_addr == c_addr_baud);

  // --------------------------------------------------------------------------
  // FIFO
  // --------------------------------------------------------------------------
  logic [7:0]  w_fifo_rdata;
  logic        w_fifo_full;
  logic        w_fifo_empty;
  logic [c_aw:0] w_fifo_level;
  logic        w_fifo_pop;

  uart_tx_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (8)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .i_push  (w_wr_data),
    .i_wdata (cmd_wdata[7:0]),
    .i_pop   (w_fifo_pop),
    .o_rdata (w_fifo_rdata),
    .o_full  (w_fifo_full),
    .o_empty (w_fifo_empty),
    .o_level (w_fifo_level)
  );

  // --------------------------------------------------------------------------
  // Status and register writes
  // --------------------------------------------------------------------------
  logic        w_busy;
  logic        w_idle;
  logic [31:0] w_status;
  logic [DIV_BITS-1:0] w_baud_wval;
  logic        w_unused_wdata;

  assign w_busy = (state_q != ST_IDLE);
  assign w_idle = w_fifo_empty && !w_busy;

  always_comb begin
    w_status                = '0;
    w_status[c_st_full]     = w_fifo_full;
    w_status[c_st_empty]    = w_fifo_empty;
    w_status[c_st_busy]     = w_busy;
    w_status[c_st_overflow] = overflow_q;
    w_status[c_st_idle]     = w_idle;
    w_status[c_st_level_lsb +: c_st_level_w] = c_st_level_w'(w_fifo_level);
  end

  // Divisors below 2 would leave no countdown room; clamp to 2.
  assign w_baud_wval = (cmd_wdata[DIV_BITS-1:0] < DIV_BITS'(2)) ? DIV_BITS'(2)
                                                                : cmd_wdata[DIV_BITS-1:0];

  // Upper write-data bits are intentionally ignored.
  assign w_unused_wdata = ^cmd_wdata;

  always_comb begin
    baud_d     = baud_q;
    overflow_d = overflow_q;
    rdata_d    = rdata_q;

    if (w_wr_baud) begin
      baud_d = w_baud_wval;
    end

    // Set has priority over the W1C clear in the same cycle.
    if (w_wr_status && cmd_wdata[c_st_overflow]) begin
      overflow_d = 1'b0;
    end
    if (w_wr_data && w_fifo_full) begin
      overflow_d = 1'b1;
    end

    // Read data reflects pre-update state of the command cycle.
    if (w_rd) begin
      case (cmd_addr)
        c_addr_status: rdata_d = w_status;
        c_addr_baud:   rdata_d = 32'(baud_q);
        default:       rdata_d = '0;
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // Transmit FSM
  // --------------------------------------------------------------------------
  logic                w_bit_done;
  logic [DIV_BITS-1:0] w_reload;

  assign w_bit_done = (timer_q == '0);
  assign w_reload   = baud_q - DIV_BITS'(1);

  always_comb begin
    state_d    = state_q;
    timer_d    = timer_q;
    bit_cnt_d  = bit_cnt_q;
    shift_d    = shift_q;
    uart_tx_d  = uart_tx_q;
    w_fifo_pop = 1'b0;

    case (state_q)
      ST_IDLE: begin
        uart_tx_d = 1'b1;
        if (!w_fifo_empty) begin
          w_fifo_pop = 1'b1;
          shift_d    = w_fifo_rdata;
          timer_d    = w_reload;
          uart_tx_d  = 1'b0;
          state_d    = ST_START;
        end
      end

      ST_START: begin
        if (w_bit_done) begin
          timer_d   = w_reload;
          bit_cnt_d = 3'd0;
          uart_tx_d = shift_q[0];
          state_d   = ST_DATA;
        end else begin
          timer_d = timer_q - DIV_BITS'(1);
        end
      end

      ST_DATA: begin
        if (w_bit_done) begin
          timer_d = w_reload;
          if (bit_cnt_q == 3'd7) begin
            uart_tx_d = 1'b1;
            state_d   = ST_STOP;
          end else begin
            // Shifter drops the bit just sent so the next one sits at [0].
            bit_cnt_d = bit_cnt_q + 3'd1;
            shift_d   = {1'b0, shift_q[7:1]};
            uart_tx_d = shift_q[1];
          end
        end else begin
          timer_d = timer_q - DIV_BITS'(1);
        end
      end

      ST_STOP: begin
        if (w_bit_done) begin
          if (!w_fifo_empty) begin
            // Chain straight into the next frame with no idle gap.
            w_fifo_pop = 1'b1;
            shift_d    = w_fifo_rdata;
            timer_d    = w_reload;
            uart_tx_d  = 1'b0;
            state_d    = ST_START;
          end else begin
            uart_tx_d = 1'b1;
            state_d   = ST_IDLE;
          end
        end else begin
          timer_d = timer_q - DIV_BITS'(1);
        end
      end

      default: begin
        uart_tx_d = 1'b1;
        state_d   = ST_IDLE;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      timer_q    <= '0;
      baud_q     <= DIV_BITS'(CLK_DIV_DEFAULT);
      bit_cnt_q  <= 3'd0;
      shift_q    <= 8'd0;
      uart_tx_q  <= 1'b1;
      overflow_q <= 1'b0;
      rdata_q    <= 32'd0;
    end else begin
      state_q    <= state_d;
      timer_q    <= timer_d;
      baud_q     <= baud_d;
      bit_cnt_q  <= bit_cnt_d;
      shift_q    <= shift_d;
      uart_tx_q  <= uart_tx_d;
      overflow_q <= overflow_d;
      rdata_q    <= rdata_d;
    end
  end

  assign rsp_rdata   = rdata_q;
  assign uart_tx     = uart_tx_q;
  assign irq_tx_idle = w_idle;

endmodule : periph_uart_tx
`default_nettype wire

// File: tb/tb_periph_uart_tx.sv
`default_nettype none
// ============================================================================
// Module      : tb_periph_uart_tx
// Description : Self-checking bench for periph_uart_tx: register access
//               vectors plus directed serial-frame sequences.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_periph_uart_tx;

  logic        clk;
  logic        reset;
  logic        cmd_valid;
  logic        cmd_wr;
  logic [1:0]  cmd_addr;
  logic [31:0] cmd_wdata;
  logic [31:0] rsp_rdata;
  logic        uart_tx;
  logic        irq_tx_idle;

  int pass_cnt = 0;
  int total_cnt = 0;
  int cyc = 0;

  periph_uart_tx #(
    .FIFO_DEPTH      (8),
    .DIV_BITS        (16),
    .CLK_DIV_DEFAULT (434)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .cmd_valid   (cmd_valid),
    .cmd_wr      (cmd_wr),
    .cmd_addr    (cmd_addr),
    .cmd_wdata   (cmd_wdata),
    .rsp_rdata   (rsp_rdata),
    .uart_tx     (uart_tx),
    .irq_tx_idle (irq_tx_idle)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  localparam logic [1:0] A_DATA = 2'd0, A_STAT = 2'd1, A_BAUD = 2'd2, A_RSVD = 2'd3;

  typedef struct {
    logic        wr;
    logic [1:0]  addr;
    logic [31:0] wdata;
    logic [31:0] exp;
    string       name;
  } vec_t;

  vec_t vecs[16];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic bus(input logic wr, input logic [1:0] a, input logic [31:0] d);
    cmd_valid = 1'b1;
    cmd_wr    = wr;
    cmd_addr  = a;
    cmd_wdata = d;
    tick();
    cmd_valid = 1'b0;
    cmd_wr    = 1'b0;
    cmd_wdata = '0;
  endtask

  // Called in the first cycle of the start bit; returns in the cycle after stop.
  // Bits with index < sw_idx (0=start, 1..8=data, 9=stop) last baud_a cycles.
  task automatic check_frame(input logic [7:0] byt, input int baud_a, input int sw_idx,
                             input int baud_b, input string name);
    for (int b = 0; b < 10; b++) begin
      logic exp;
      logic got;
      int   n;
      exp = (b == 0) ? 1'b0 : (b == 9) ? 1'b1 : byt[b-1];
      got = exp;
      n   = (b < sw_idx) ? baud_a : baud_b;
      for (int c = 0; c < n; c++) begin
        if (uart_tx !== exp && got === exp) got = uart_tx;
        tick();
      end
      check($sformatf("%s bit%0d", name, b), {31'd0, got}, {31'd0, exp});
    end
  endtask

  task automatic wait_idle(input int max, input string name);
    int n = 0;
    while (irq_tx_idle !== 1'b1 && n < max) begin
      tick();
      n++;
    end
    check({name, " idle timeout"}, {31'd0, irq_tx_idle}, 32'd1);
  endtask

  task automatic wait_until(input int target);
    while (cyc < target) tick();
  endtask

  initial begin
    int n0;
    int s0;
    logic saw_low;

    // Register access vectors (reads compare rsp_rdata one cycle later)
    vecs[0]  = '{1'b0, A_DATA, 32'h0,        32'h0,        "rd DATA"};
    vecs[1]  = '{1'b0, A_STAT, 32'h0,        32'h12,       "rd STATUS reset"};
    vecs[2]  = '{1'b0, A_BAUD, 32'h0,        32'd434,      "rd BAUD reset"};
    vecs[3]  = '{1'b0, A_RSVD, 32'h0,        32'h0,        "rd RSVD"};
    vecs[4]  = '{1'b1, A_RSVD, 32'hFFFFFFFF, 32'h0,        "wr RSVD"};
    vecs[5]  = '{1'b0, A_RSVD, 32'h0,        32'h0,        "rd RSVD after wr"};
    vecs[6]  = '{1'b1, A_BAUD, 32'h0,        32'h0,        "wr BAUD 0"};
    vecs[7]  = '{1'b0, A_BAUD, 32'h0,        32'd2,        "rd BAUD 0->2"};
    vecs[8]  = '{1'b1, A_BAUD, 32'h1,        32'h0,        "wr BAUD 1"};
    vecs[9]  = '{1'b0, A_BAUD, 32'h0,        32'd2,        "rd BAUD 1->2"};
    vecs[10] = '{1'b1, A_BAUD, 32'hABCD1234, 32'h0,        "wr BAUD wide"};
    vecs[11] = '{1'b0, A_BAUD, 32'h0,        32'h1234,     "rd BAUD wide"};
    vecs[12] = '{1'b1, A_STAT, 32'hFFFFFFFF, 32'h0,        "wr STATUS ones"};
    vecs[13] = '{1'b0, A_STAT, 32'h0,        32'h12,       "rd STATUS unchanged"};
    vecs[14] = '{1'b1, A_BAUD, 32'h3,        32'h0,        "wr BAUD 3"};
    vecs[15] = '{1'b0, A_BAUD, 32'h0,        32'd3,        "rd BAUD 3"};

    reset     = 1'b1;
    cmd_valid = 1'b0;
    cmd_wr    = 1'b0;
    cmd_addr  = '0;
    cmd_wdata = '0;
    #12;
    check("reset uart_tx", {31'd0, uart_tx}, 32'd1);
    check("reset irq", {31'd0, irq_tx_idle}, 32'd1);
    check("reset rdata", rsp_rdata, 32'd0);
    @(posedge clk);
    #1 reset = 1'b0;
    tick();

    for (int i = 0; i < 16; i++) begin
      bus(vecs[i].wr, vecs[i].addr, vecs[i].wdata);
      if (!vecs[i].wr) check(vecs[i].name, rsp_rdata, vecs[i].exp);
    end

    // ---- Single frame 0x55 at BAUD=4 ----
    bus(1'b1, A_BAUD, 32'd4);
    bus(1'b1, A_DATA, 32'h55);                 // now cycle N+1
    check("t1 high at N+1", {31'd0, uart_tx}, 32'd1);
    tick();                                    // cycle N+2: start bit
    check_frame(8'h55, 4, 10, 4, "t1");
    check("t1 idle at N+42", {31'd0, irq_tx_idle}, 32'd1);

    // ---- Read-sampling timing around a DATA write ----
    bus(1'b1, A_DATA, 32'hA3);                 // cycle N
    bus(1'b0, A_STAT, 32'h0);                  // read in N+1: not yet popped
    check("t6 status N+1", rsp_rdata, 32'h100);
    bus(1'b0, A_STAT, 32'h0);                  // read in N+2: popped, busy
    check("t6 status N+2", rsp_rdata, 32'h006);
    wait_idle(100, "t6");
    bus(1'b1, A_RSVD, 32'h1);
    check("t6 rdata holds", rsp_rdata, 32'h006);

    // ---- FIFO fill, overflow, back-to-back frames ----
    bus(1'b1, A_BAUD, 32'd100);
    n0 = cyc;
    for (int i = 0; i < 10; i++) bus(1'b1, A_DATA, 32'(i));
    bus(1'b0, A_STAT, 32'h0);
    check("t2 status full+ovf", rsp_rdata, 32'h80D);
    bus(1'b1, A_STAT, 32'h8);
    bus(1'b0, A_STAT, 32'h0);
    check("t3 ovf cleared", rsp_rdata, 32'h805);
    wait_until(n0 + 2 + 1000);
    for (int i = 1; i <= 8; i++) check_frame(8'(i), 100, 10, 100, $sformatf("t3 f%0d", i));
    check("t2 idle after 8", {31'd0, irq_tx_idle}, 32'd1);
    saw_low = 1'b0;
    for (int c = 0; c < 300; c++) begin
      if (uart_tx !== 1'b1) saw_low = 1'b1;
      tick();
    end
    check("t2 byte 9 dropped", {31'd0, saw_low}, 32'd0);
    bus(1'b0, A_STAT, 32'h0);
    check("t2 status final", rsp_rdata, 32'h12);

    // ---- BAUD change mid-frame ----
    bus(1'b1, A_BAUD, 32'd8);
    bus(1'b1, A_DATA, 32'hA5);
    tick();                                    // start bit cycle S
    fork
      check_frame(8'hA5, 8, 4, 16, "t4");
      begin
        repeat (26) tick();                    // S+26: inside data bit 2
        bus(1'b1, A_BAUD, 32'd16);
      end
    join
    wait_idle(50, "t4");

    // ---- Asynchronous reset mid-frame ----
    bus(1'b1, A_DATA, 32'h07);                 // cycle N
    tick();                                    // N+2: start bit
    s0 = cyc;
    bus(1'b1, A_DATA, 32'h11);
    bus(1'b1, A_DATA, 32'h22);
    wait_until(s0 + 70);                       // inside data bit 3 (value 0)
    check("t5 bit3 low", {31'd0, uart_tx}, 32'd0);
    #3 reset = 1'b1;
    #1;
    check("t5 async tx high", {31'd0, uart_tx}, 32'd1);
    check("t5 async irq", {31'd0, irq_tx_idle}, 32'd1);
    @(posedge clk);
    #1 reset = 1'b0;
    check("t5 rdata reset", rsp_rdata, 32'd0);
    tick();
    bus(1'b0, A_STAT, 32'h0);
    check("t5 status", rsp_rdata, 32'h12);
    bus(1'b0, A_BAUD, 32'h0);
    check("t5 baud", rsp_rdata, 32'd434);
    saw_low = 1'b0;
    for (int c = 0; c < 50; c++) begin
      if (uart_tx !== 1'b1) saw_low = 1'b1;
      tick();
    end
    check("t5 fifo discarded", {31'd0, saw_low}, 32'd0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule : tb_periph_uart_tx
`default_nettype wire
